// File: rtl/div_pkg.sv
// div_pkg: shared width, divide-class opcodes and sequencer states for div_sequencer.
package div_pkg;
  localparam int XLEN = 32;
  localparam logic [4:0] DIV  = 5'b01100;
  localparam logic [4:0] DIVU = 5'b01101;
  localparam logic [4:0] REM  = 5'b01110;
  localparam logic [4:0] REMU = 5'b01111;
  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;
  function automatic logic is_div_op(input logic [4:0] op);
    return op[4:2] == 3'b011;
  endfunction
endpackage

// File: rtl/div_sequencer_if.sv
// div_sequencer_if: execute-stage request/result bundle between control (master) and divider (slave).
interface div_sequencer_if;
  import div_pkg::*;
  logic            start;
  logic [4:0]      alu_opcode;
  logic [XLEN-1:0] data1;
  logic [XLEN-1:0] data2;
  logic            flush;
  logic            stall;
  logic            busy;
  logic            valid;
  logic [XLEN-1:0] result;
  modport master(output start, alu_opcode, data1, data2, flush, input stall, busy, valid, result);
  modport slave(input start, alu_opcode, data1, data2, flush, output stall, busy, valid, result);
endinterface

// File: rtl/div_step.sv
// div_step: one combinational radix-2 restoring division iteration.
module div_step
  import div_pkg::*;
(
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);
  logic [XLEN:0] shifted, diff;
  assign shifted  = {rem, quo[XLEN-1]};
  // rem < divisor keeps the difference inside XLEN+1 signed range
  assign diff     = shifted - {1'b0, divisor};
  assign rem_next = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
  assign quo_next = {quo[XLEN-2:0], ~diff[XLEN]};
endmodule

// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle RV32M DIV/DIVU/REM/REMU sequencer with pipeline stall.
// Define DIV_EARLY_OUT_EN to skip CALC when |dividend| < |divisor|.
module div_sequencer
  import div_pkg::*;
(
  input logic CLK,
  input logic RESET,
  div_sequencer_if.slave bus
);
  state_t state, next;
  logic [1:0]      op;
  logic [XLEN-1:0] rem, quo, dvs, result, abs_a, abs_b, step_rem, step_quo, special_res;
  logic [4:0]      cnt;
  logic            q_neg, r_neg, accept, sgn, special;
  assign accept      = bus.start & is_div_op(bus.alu_opcode) & ~bus.flush;
  assign sgn         = ~op[0];
  assign abs_a       = (sgn & quo[XLEN-1]) ? -quo : quo;
  assign abs_b       = (sgn & dvs[XLEN-1]) ? -dvs : dvs;
  assign special     = (dvs == '0) | (sgn & quo == 32'h8000_0000 & dvs == '1);
  assign special_res = (dvs == '0) ? (op[1] ? quo : '1) : (op[1] ? '0 : 32'h8000_0000);
  div_step u_step (
    .rem     (rem),
    .quo     (quo),
    .divisor (dvs),
    .rem_next(step_rem),
    .quo_next(step_quo)
  );
  always_comb begin
    next = state;
    case (state)
      IDLE: next = accept ? PREP : IDLE;
`ifdef DIV_EARLY_OUT_EN
      PREP: next = special ? DONE : (abs_a < abs_b) ? FIX : CALC;
`else
      PREP: next = special ? DONE : CALC;
`endif
      CALC: next = (cnt == 5'd31) ? FIX : CALC;
      FIX:  next = DONE;
      DONE: next = IDLE;
      default: next = IDLE;
    endcase
    if (bus.flush && state != IDLE) next = IDLE;
  end
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state  <= IDLE;
      op     <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      cnt    <= '0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      result <= '0;
    end else begin
      state <= next;
      if (state == IDLE && accept) begin
        op  <= bus.alu_opcode[1:0];
        quo <= bus.data1;
        dvs <= bus.data2;
        rem <= '0;
        cnt <= '0;
      end else if (!bus.flush) begin
        case (state)
          PREP: begin
            q_neg <= sgn & (quo[XLEN-1] ^ dvs[XLEN-1]);
            r_neg <= sgn & quo[XLEN-1];
            dvs   <= abs_b;
            cnt   <= '0;
`ifdef DIV_EARLY_OUT_EN
            rem   <= (abs_a < abs_b) ? abs_a : '0;
            quo   <= (abs_a < abs_b) ? '0 : abs_a;
`else
            rem   <= '0;
            quo   <= abs_a;
`endif
            if (special) result <= special_res;
          end
          CALC: begin
            rem <= step_rem;
            quo <= step_quo;
            cnt <= cnt + 5'd1;
          end
          FIX: result <= op[1] ? (r_neg ? -rem : rem) : (q_neg ? -quo : quo);
          default: ;
        endcase
      end
    end
  end
  assign bus.busy   = state != IDLE;
  assign bus.valid  = state == DONE;
  assign bus.stall  = (bus.busy & ~bus.valid) | (state == IDLE & accept);
  assign bus.result = result;
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: randomized and directed checks of div_sequencer against an arithmetic reference.
module tb_div_sequencer;
  import div_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  div_sequencer_if bus();
  div_sequencer dut (.CLK(clk), .RESET(rst_n), .bus(bus));
  int errors = 0, checks = 0;
  int k = 0, lat = 0, cyc = 0, start_cyc = 0, got_lat = -1;
  logic [31:0] pend = '0, exp_res = '0, got_res = '0;

  function automatic logic is_div(input logic [4:0] op);
    return op >= 5'd12 && op <= 5'd15;
  endfunction

  function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'(a);
    longint ub = longint'(b);
    case (op)
      5'd12:   return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
      5'd13:   return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
      5'd14:   return (b == 0) ? a : 32'(sa % sb);
      default: return (b == 0) ? a : 32'(ua % ub);
    endcase
  endfunction

  function automatic int ref_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic sgn = (op == 5'd12 || op == 5'd14);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint aa = sgn ? (sa < 0 ? -sa : sa) : longint'(a);
    longint ab = sgn ? (sb < 0 ? -sb : sb) : longint'(b);
    if (b == 0) return 2;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
`ifdef DIV_EARLY_OUT_EN
    if (aa < ab) return 3;
`else
    if (aa < ab) return 35;
`endif
    return 35;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  task automatic compare();
    check("busy", 32'(bus.busy), 32'(k != 0));
    check("valid", 32'(bus.valid), 32'(k != 0 && k == lat));
    check("stall", 32'(bus.stall), 32'((k != 0 && k != lat) || (k == 0 && bus.start && is_div(bus.alu_opcode) && !bus.flush)));
    check("result", bus.result, exp_res);
    if (bus.valid) begin
      got_res = bus.result;
      got_lat = cyc - start_cyc;
    end
  endtask

  task automatic update();
    if (k == 0) begin
      if (bus.start && is_div(bus.alu_opcode) && !bus.flush) begin
        pend = ref_result(bus.alu_opcode, bus.data1, bus.data2);
        lat = ref_lat(bus.alu_opcode, bus.data1, bus.data2);
        start_cyc = cyc;
        k = 1;
      end
    end else if (bus.flush || k == lat) k = 0;
    else begin
      k++;
      if (k == lat) exp_res = pend;
    end
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
    @(posedge clk);
    update();
    #1;
  endtask

  task automatic wait_idle(input bit noise);
    for (int i = 0; i < 60 && k != 0; i++) begin
      if (noise) begin
        bus.start = $urandom_range(1);
        bus.alu_opcode = 5'(12 + $urandom_range(3));
        bus.data1 = $urandom;
        bus.data2 = $urandom;
      end
      tick();
    end
    bus.start = 1'b0;
    if (k != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: got busy expected idle at cycle %0d", cyc);
      k = 0;
    end
  endtask

  task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat, input bit noise);
    bus.start = 1'b1;
    bus.alu_opcode = op;
    bus.data1 = a;
    bus.data2 = b;
    got_lat = -1;
    tick();
    bus.start = 1'b0;
    wait_idle(noise);
    check({name, "_res"}, got_res, exp);
    check({name, "_lat"}, 32'(got_lat), 32'(exp_lat));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int eo;
`ifdef DIV_EARLY_OUT_EN
    eo = 3;
`else
    eo = 35;
`endif
    bus.start = 1'b0;
    bus.alu_opcode = '0;
    bus.data1 = '0;
    bus.data2 = '0;
    bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_valid", 32'(bus.valid), 32'd0);
    check("rst_result", bus.result, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op("div_100_7", DIV, 32'd100, 32'd7, 32'd14, 35, 1'b0);
    run_op("rem_100_7", REM, 32'd100, 32'd7, 32'd2, 35, 1'b1);
    run_op("div_m100_7", DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 35, 1'b0);
    run_op("rem_m100_7", REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 35, 1'b0);
    run_op("divu_big_7", DIVU, 32'hFFFF_FF9C, 32'd7, 32'h2492_4916, 35, 1'b1);
    run_op("remu_big_7", REMU, 32'hFFFF_FF9C, 32'd7, 32'd2, 35, 1'b0);
    run_op("div_5_0", DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 2, 1'b0);
    run_op("rem_5_0", REM, 32'd5, 32'd0, 32'd5, 2, 1'b0);
    run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, 1'b0);
    run_op("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2, 1'b0);
    run_op("divu_3_10", DIVU, 32'd3, 32'd10, 32'd0, eo, 1'b0);
    run_op("remu_3_10", REMU, 32'd3, 32'd10, 32'd3, eo, 1'b0);
    // flush in cycle 10, new op accepted in cycle 11
    bus.start = 1'b1;
    bus.alu_opcode = DIV;
    bus.data1 = 32'd1000;
    bus.data2 = 32'd3;
    got_lat = -1;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_no_valid", 32'(got_lat), 32'hFFFF_FFFF);
    check("flush_result_kept", bus.result, 32'd3);
    run_op("after_flush", REM, 32'd100, 32'd7, 32'd2, 35, 1'b0);
    // asynchronous reset in the middle of CALC
    bus.start = 1'b1;
    bus.alu_opcode = DIVU;
    bus.data1 = 32'd77;
    bus.data2 = 32'd5;
    tick();
    bus.start = 1'b0;
    repeat (10) tick();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_stall", 32'(bus.stall), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_valid", 32'(bus.valid), 32'd0);
    check("mid_rst_result", bus.result, 32'd0);
    k = 0;
    exp_res = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3000; i++) begin
      bus.start = ($urandom_range(3) == 0);
      bus.alu_opcode = ($urandom_range(4) == 0) ? 5'($urandom) : 5'(12 + $urandom_range(3));
      bus.data1 = pick();
      bus.data2 = pick();
      bus.flush = ($urandom_range(39) == 0);
      tick();
    end
    bus.start = 1'b0;
    bus.flush = 1'b0;
    wait_idle(1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
